// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   pipe_state_t / ST_*  : occupancy of a stage (EMPTY, FULL = main valid, SKID = main + skid valid)
//   CTRL_*               : bit positions inside the control payload
//   PC_RST               : reset value used for the PC+4 data field
package pipe_pkg;

  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t ST_EMPTY = 2'd0;
  localparam pipe_state_t ST_FULL  = 2'd1;
  localparam pipe_state_t ST_SKID  = 2'd2;

  localparam int CTRL_WREG_EN = 0;
  localparam int CTRL_WMEM_EN = 1;
  localparam int CTRL_MEM2REG = 2;
  localparam int CTRL_ALU_IMM = 3;
  localparam int CTRL_SHIFT   = 4;
  localparam int CTRL_JAL     = 5;

  localparam logic [31:0] PC_RST = 32'h3000;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload bus between pipeline stages.
//   valid : producer has a transfer
//   ready : consumer accepts; transfer when valid & ready
//   ctrl  : control payload (CTRL_W)
//   data  : data payload (DATA_W)
// master = producer side, slave = consumer side.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, ctrl, data, input  ready);
  modport slave  (input  valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry ctrl+data holding register with valid.
//   Clk, Reset     : clock, async active-high reset
//   ld             : capture d_ctrl/d_data, become valid
//   clr            : drop the entry (wins over ld)
//   d_ctrl, d_data : incoming payload
//   valid          : entry held
//   ctrl, data     : held payload; ctrl is 0 whenever valid is 0
module pipe_skid_buf #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ld,
  input  logic              clr,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (ld) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with valid/ready
// flow control, flush (bubble insertion) and a saturating stall counter.
//   Clk, Reset : clock (rising edge), async active-high reset
//   flush      : kill held and incoming contents at this edge
//   up         : upstream bus (slave): up.ready is in_ready
//   dn         : downstream bus (master): dn.ctrl is 0 whenever dn.valid is 0
//   stall_cnt  : saturating count of cycles with dn.valid & !dn.ready
// Build option PIPE_STAGE_SKID_EN: adds a skid entry so up.ready is a pure
// flop output (no combinational dn.ready -> up.ready path). Without it the
// stage is a single register with up.ready = !dn.valid | dn.ready.
// Output sequence is the same in both builds for the same accepted inputs.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 8,
  parameter logic [DATA_W-1:0] RST_DATA = '0,
  parameter int                CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              in_xfer;
  pipe_state_t       state;
  // main register actions for this edge (flush handled separately)
  logic              ld_in, ld_skid, ld_bubble;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign dn.valid = main_valid;
  assign dn.ctrl  = main_ctrl;
  assign dn.data  = main_data;
  assign in_xfer  = up.valid & up.ready;

`ifdef PIPE_STAGE_SKID_EN
  logic skid_ld, skid_clr;

  assign up.ready = !skid_valid;
  assign state    = skid_valid ? ST_SKID : (main_valid ? ST_FULL : ST_EMPTY);

  pipe_skid_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .Clk    (Clk),
    .Reset  (Reset),
    .ld     (skid_ld),
    .clr    (skid_clr),
    .d_ctrl (up.ctrl),
    .d_data (up.data),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .data   (skid_data)
  );

  always_comb begin
    ld_in     = 1'b0;
    ld_skid   = 1'b0;
    ld_bubble = 1'b0;
    skid_ld   = 1'b0;
    skid_clr  = flush;
    if (!flush) begin
      case (state)
        ST_EMPTY: ld_in = in_xfer;
        ST_FULL: begin
          // stalled with a new word arriving: park it behind main
          if (in_xfer && !dn.ready) skid_ld   = 1'b1;
          else if (in_xfer)         ld_in     = 1'b1;
          else if (dn.ready)        ld_bubble = 1'b1;
        end
        ST_SKID: begin
          if (dn.ready) begin
            ld_skid  = 1'b1;
            skid_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign skid_valid = 1'b0;
  assign skid_ctrl  = '0;
  assign skid_data  = '0;
  assign up.ready   = !main_valid | dn.ready;
  assign state      = main_valid ? ST_FULL : ST_EMPTY;

  always_comb begin
    ld_in     = 1'b0;
    ld_skid   = skid_valid;
    ld_bubble = 1'b0;
    if (!flush) begin
      case (state)
        ST_EMPTY: ld_in = in_xfer;
        ST_FULL: begin
          if (in_xfer)       ld_in     = 1'b1;
          else if (dn.ready) ld_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end
`endif

  // data is held on a bubble; only ctrl is forced to zero
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= RST_DATA;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
    end else if (ld_in) begin
      main_valid <= 1'b1;
      main_ctrl  <= up.ctrl;
      main_data  <= up.data;
    end else if (ld_skid) begin
      main_valid <= 1'b1;
      main_ctrl  <= skid_ctrl;
      main_data  <= skid_data;
    end else if (ld_bubble) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
    end
  end

  // counts regardless of flush; only Reset clears it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      stall_cnt <= '0;
    else if (main_valid && !dn.ready && !(&stall_cnt))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] d;
  } ent_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        flush, flush2;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt2;
  int          n_tests = 0;
  int          n_fail  = 0;
  ent_t        sb[$];
  logic [15:0] exp_cnt;

  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32)) up ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32)) dn ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32)) up2 ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32)) dn2 ();

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .RST_DATA(PC_RST), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .flush(flush), .up(up), .dn(dn), .stall_cnt(stall_cnt));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .RST_DATA(PC_RST), .CNT_W(4)) dut2 (
    .Clk(Clk), .Reset(Reset), .flush(flush2), .up(up2), .dn(dn2), .stall_cnt(stall_cnt2));

  always #5 Clk = ~Clk;

  // Called at a negedge: drives one cycle, updates the scoreboard and the
  // stall-count model for the coming edge, returns at the next negedge.
  task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d,
                       input logic ordy, input logic fl, output logic acc);
    ent_t tmp;
    up.valid = v; up.ctrl = c; up.data = d; dn.ready = ordy; flush = fl;
    #1;
    acc = v & up.ready & !fl;
    if (dn.valid && !ordy && exp_cnt != 16'hFFFF) exp_cnt++;
    if (fl) sb.delete();
    else begin
      if (dn.valid && ordy && sb.size() != 0) tmp = sb.pop_front();
      if (acc) sb.push_back({c, d});
    end
    @(negedge Clk);
  endtask

  task automatic test_reset;
    Reset = 1'b1; flush = 1'b0; flush2 = 1'b0;
    up.valid = 1'b0; up.ctrl = '0; up.data = '0; dn.ready = 1'b0;
    up2.valid = 1'b0; up2.ctrl = '0; up2.data = '0; dn2.ready = 1'b0;
    repeat (2) @(negedge Clk);
    n_tests++;
    if (dn.valid !== 1'b0 || dn.ctrl !== 8'h0 || dn.data !== 32'h3000 || stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b c=%h d=%h cnt=%0d want v=0 c=00 d=00003000 cnt=0",
               dn.valid, dn.ctrl, dn.data, stall_cnt);
    end
    Reset = 1'b0; sb.delete(); exp_cnt = '0;
    @(negedge Clk);
  endtask

  task automatic test_stream;
    logic acc;
    for (int i = 1; i <= 9; i++) begin
      drive(i <= 8, 8'(i), 32'(i), 1'b1, 1'b0, acc);
      n_tests++;
      if (dn.valid !== (sb.size() != 0) || (dn.valid === 1'b0 && dn.ctrl !== 8'h0) ||
          (sb.size() != 0 && {dn.ctrl, dn.data} !== sb[0])) begin
        n_fail++;
        $display("FAIL stream_out got v=%b c=%h d=%h want v=%0d front=%h",
                 dn.valid, dn.ctrl, dn.data, sb.size() != 0, sb.size() != 0 ? sb[0] : '0);
      end
      if (i <= 8) begin
        n_tests++;
        if (dn.valid !== 1'b1 || dn.data !== 32'(i)) begin
          n_fail++;
          $display("FAIL stream_latency got v=%b d=%0d want v=1 d=%0d", dn.valid, dn.data, i);
        end
      end
    end
    n_tests++;
    if (stall_cnt !== 16'h0) begin
      n_fail++; $display("FAIL stream_stall_cnt got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_stall;
    logic acc, ordy;
    int idx = 1, left = 3, guard = 0;
    while ((idx <= 8 || sb.size() != 0) && guard < 60) begin
      ordy = !(dn.valid === 1'b1 && dn.data == 32'd5 && left > 0);
      if (!ordy) left--;
      drive(idx <= 8, 8'(idx), 32'(idx), ordy, 1'b0, acc);
      if (acc) idx++;
      n_tests++;
      if (dn.valid !== (sb.size() != 0) || (dn.valid === 1'b0 && dn.ctrl !== 8'h0) ||
          (sb.size() != 0 && {dn.ctrl, dn.data} !== sb[0])) begin
        n_fail++;
        $display("FAIL stall_out got v=%b c=%h d=%h want v=%0d front=%h",
                 dn.valid, dn.ctrl, dn.data, sb.size() != 0, sb.size() != 0 ? sb[0] : '0);
      end
      if (!ordy) begin
        n_tests++;
        if (dn.valid !== 1'b1 || dn.data !== 32'd5) begin
          n_fail++; $display("FAIL stall_hold got v=%b d=%0d want v=1 d=5", dn.valid, dn.data);
        end
      end
      guard++;
    end
    n_tests++;
    if (guard >= 60) begin
      n_fail++; $display("FAIL stall_timeout got idx=%0d pending=%0d want all 8 delivered", idx, sb.size());
    end
    n_tests++;
    if (stall_cnt !== 16'd3) begin
      n_fail++; $display("FAIL stall_cnt got %0d want 3", stall_cnt);
    end
  endtask

  task automatic test_flush;
    logic acc;
    drive(1'b1, 8'h01, 32'hAA, 1'b0, 1'b0, acc);
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, acc);
    n_tests++;
    if (dn.valid !== 1'b1 || dn.data !== 32'hAA || dn.ctrl !== 8'h01) begin
      n_fail++; $display("FAIL flush_pre got v=%b c=%h d=%h want v=1 c=01 d=aa", dn.valid, dn.ctrl, dn.data);
    end
    drive(1'b1, 8'hFF, 32'hBB, 1'b0, 1'b1, acc);
    n_tests++;
    if (dn.valid !== 1'b0 || dn.ctrl !== 8'h00) begin
      n_fail++; $display("FAIL flush_kill got v=%b c=%h want v=0 c=00", dn.valid, dn.ctrl);
    end
    drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
    n_tests++;
    if (dn.valid !== 1'b0 || dn.ctrl !== 8'h00 || sb.size() != 0) begin
      n_fail++; $display("FAIL flush_after got v=%b c=%h want v=0 c=00", dn.valid, dn.ctrl);
    end
  endtask

  task automatic test_reset_mid;
    logic acc;
    drive(1'b1, 8'h3C, 32'h77, 1'b0, 1'b0, acc);
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, acc);
    n_tests++;
    if (dn.valid !== 1'b1 || stall_cnt === 16'h0) begin
      n_fail++; $display("FAIL rstmid_pre got v=%b cnt=%0d want v=1 cnt>0", dn.valid, stall_cnt);
    end
    Reset = 1'b1;
    #1;
    n_tests++;
    if (dn.valid !== 1'b0 || dn.ctrl !== 8'h0 || dn.data !== 32'h3000 || stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL rstmid_state got v=%b c=%h d=%h cnt=%0d want v=0 c=00 d=00003000 cnt=0",
               dn.valid, dn.ctrl, dn.data, stall_cnt);
    end
    @(negedge Clk);
    Reset = 1'b0; sb.delete(); exp_cnt = '0;
    @(negedge Clk);
  endtask

  task automatic test_saturate;
    up2.valid = 1'b1; up2.ctrl = 8'h5A; up2.data = 32'd9; dn2.ready = 1'b0;
    @(negedge Clk);
    up2.valid = 1'b0;
    repeat (5) @(negedge Clk);
    n_tests++;
    if (stall_cnt2 !== 4'd5) begin
      n_fail++; $display("FAIL sat_mid got %0d want 5", stall_cnt2);
    end
    repeat (15) @(negedge Clk);
    n_tests++;
    if (stall_cnt2 !== 4'd15 || dn2.valid !== 1'b1 || dn2.data !== 32'd9 || dn2.ctrl !== 8'h5A) begin
      n_fail++;
      $display("FAIL sat_end got cnt=%0d v=%b c=%h d=%0d want cnt=15 v=1 c=5a d=9",
               stall_cnt2, dn2.valid, dn2.ctrl, dn2.data);
    end
  endtask

  task automatic test_random;
    logic acc;
    int bad = 0;
    for (int k = 0; k < 10000; k++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0, acc);
      n_tests++;
      if (dn.valid !== (sb.size() != 0) || (dn.valid === 1'b0 && dn.ctrl !== 8'h0) ||
          (sb.size() != 0 && {dn.ctrl, dn.data} !== sb[0])) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random_out cyc=%0d got v=%b c=%h d=%h want v=%0d front=%h", k,
                   dn.valid, dn.ctrl, dn.data, sb.size() != 0, sb.size() != 0 ? sb[0] : '0);
        bad++;
      end
    end
    n_tests++;
    if (stall_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL random_stall_cnt got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
